piso_bit_serializer: RTL and testbench
======================================

Name: piso_bit_serializer

Overview:
- Parallel-in/serial-out stage directly upstream of the serial sequence-detector FSM.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on ser_out, which drives the detector's `in` input.
- A one-word holding register allows back-to-back words to stream with no idle bit between them, so sequences spanning a word boundary are still detected.

Parameters:
- WIDTH, 8, word width in bits (>= 2).
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- ser_en  input  1  bit-advance enable (throttle); when low, the current bit is held.
- ser_out  output  1  serial bit; connects to the detector's `in`.
- ser_valid  output  1  ser_out carries a real data bit.
- busy  output  1  shifter or holding register is occupied.
- word_done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, bit counter=0, holding register empty.
  - ser_out=0, ser_valid=0, busy=0, word_done=0, load_ready=1.
  - Any word in flight or held is discarded.
- All outputs are registered. load_ready = !hold_full, taken from the register.
- Accept: a word is accepted on a rising edge where load_valid && load_ready.
- States:
  - IDLE: ser_valid=0, ser_out=0. An accept loads the shifter directly, sets cnt=0 and goes to SHIFT. After that edge, ser_out = first bit and ser_valid=1. ser_en is not required to load.
  - SHIFT: ser_valid=1.
    - Edge with ser_en=1 and cnt<WIDTH-1: shift one bit, cnt+1.
    - Edge with ser_en=0: shifter and cnt hold. An accept may still fill the holding register.
    - Edge with ser_en=1 and cnt==WIDTH-1 (last bit consumed): word_done=1 for the next cycle. Then one of:
      - Holding register full: move it into the shifter, cnt=0, stay in SHIFT, hold becomes empty. No gap bit.
      - Holding register empty and an accept on the same edge: load the accepted word directly into the shifter. No gap bit.
      - Otherwise: go to IDLE, ser_valid=0, ser_out=0.
- In SHIFT, an accept that is not on a last-bit edge loads the holding register. load_ready drops the following cycle.
- Accept with both shifter and holding register occupied is impossible, because load_ready=0.
- busy = (state==SHIFT) || hold_full.
- Bit order follows MSB_FIRST. With MSB_FIRST=1, shift left and send shreg[WIDTH-1]. With MSB_FIRST=0, shift right and send shreg[0].
- Bit counter width is $clog2(WIDTH). It never exceeds WIDTH-1.

Decomposition:
- Shared package fsm_pkg:
  - State enum {IDLE, SHIFT}.
  - Default WIDTH constant.
  - Detector pattern constant 3'b101, for bench reuse.
- No sub-module; the holding register is inline.
- The bench top instantiates piso_bit_serializer feeding the existing sequence detector.

Test Plan:
- Single word: WIDTH=8, MSB_FIRST=1, load 8'hA0, ser_en=1 → ser_out 1,0,1,0,0,0,0,0 over 8 cycles with ser_valid high. word_done pulses once, then IDLE. The downstream detector q pulses once, on the 3rd bit.
- Back-to-back: load 8'hA5 then 8'h3C, load_valid held → 16 contiguous valid bits 10100101_00111100 with no gap. load_ready low while the hold is full. Two word_done pulses, 8 cycles apart.
- Throttle: ser_en=0 for 3 cycles after bit 2 of 8'hA0 → ser_out stays 1 for those cycles, then the sequence resumes. Total 11 cycles of ser_valid.
- Hold full: shifter and hold occupied, third word presented → load_ready=0, third word accepted only after the transfer edge. Data order is preserved.
- LSB-first: MSB_FIRST=0, load 8'h05 → ser_out 1,0,1,0,0,0,0,0.
- Reset mid-word: assert rst asynchronously between edges after bit 3 → ser_valid, ser_out and busy go 0 immediately, and load_ready=1. The next word after release starts at cnt=0.

Source files
------------

// File: rtl/piso_bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer_pkg
// Shared definitions for the parallel-in/serial-out stage that feeds the serial
// sequence detector.
//   state_t         : serializer control states (IDLE, SHIFT)
//   DEFAULT_WIDTH   : default word width in bits
//   DETECT_PATTERN  : bit pattern the downstream detector looks for (oldest bit
//                     first); kept here so the bench and the detector agree
// -----------------------------------------------------------------------------
package piso_bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] DETECT_PATTERN = 3'b101;

endpackage : piso_bit_serializer_pkg

// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
// Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit
// per enabled clock. A one-word holding register lets consecutive words stream
// with no idle bit between them.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   load_data  in   [WIDTH-1:0] word to serialize
//   load_valid in   load_data is valid
//   load_ready out  a word can be accepted this cycle (= holding register empty)
//   ser_en     in   bit-advance enable; low holds the current bit
//   ser_out    out  serial data bit (0 when idle)
//   ser_valid  out  ser_out carries a real data bit
//   busy       out  shifter or holding register occupied
//   word_done  out  one-cycle pulse after the last bit of a word is consumed
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module piso_bit_serializer
    import piso_bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             ser_en,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [WIDTH-1:0]   hold_reg, hold_next;
    logic               hold_full_reg, hold_full_next;

    logic               ser_out_reg, ser_out_next;
    logic               ser_valid_reg, ser_valid_next;
    logic               busy_reg, busy_next;
    logic               word_done_reg, word_done_next;
    logic               load_ready_reg, load_ready_next;

    logic [WIDTH-1:0]   shreg_shifted;
    logic               first_bit_next;
    logic               accept;
    logic               last_bit;

    // Bit order: the bit on the wire is always at the "outgoing" end of the
    // shifter, so the next-cycle output can be read from shreg_next directly.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shreg_shifted  = {shreg_reg[WIDTH-2:0], 1'b0};
            assign first_bit_next = shreg_next[WIDTH-1];
        end else begin : g_lsb_first
            assign shreg_shifted  = {1'b0, shreg_reg[WIDTH-1:1]};
            assign first_bit_next = shreg_next[0];
        end
    endgenerate

    assign accept   = load_valid && load_ready_reg;
    assign last_bit = ser_en && (cnt_reg == LAST_CNT);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        cnt_next       = cnt_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        word_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                // The holding register is always empty here; an accepted word
                // goes straight into the shifter without waiting for ser_en.
                if (accept) begin
                    shreg_next = load_data;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                if (last_bit) begin
                    word_done_next = 1'b1;
                    if (hold_full_reg) begin
                        // load_ready is low, so no accept can collide here.
                        shreg_next     = hold_reg;
                        cnt_next       = '0;
                        hold_full_next = 1'b0;
                    end else if (accept) begin
                        shreg_next = load_data;
                        cnt_next   = '0;
                    end else begin
                        shreg_next = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    if (ser_en) begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                    if (accept) begin
                        hold_next      = load_data;
                        hold_full_next = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output flops are fed from next-state values so every output is registered
    // yet reflects the state it describes in the same cycle.
    assign ser_valid_next  = (state_next == SHIFT);
    assign ser_out_next    = (state_next == SHIFT) && first_bit_next;
    assign busy_next       = (state_next == SHIFT) || hold_full_next;
    assign load_ready_next = !hold_full_next;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            shreg_reg      <= '0;
            cnt_reg        <= '0;
            hold_reg       <= '0;
            hold_full_reg  <= 1'b0;
            ser_out_reg    <= 1'b0;
            ser_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            word_done_reg  <= 1'b0;
            load_ready_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            shreg_reg      <= shreg_next;
            cnt_reg        <= cnt_next;
            hold_reg       <= hold_next;
            hold_full_reg  <= hold_full_next;
            ser_out_reg    <= ser_out_next;
            ser_valid_reg  <= ser_valid_next;
            busy_reg       <= busy_next;
            word_done_reg  <= word_done_next;
            load_ready_reg <= load_ready_next;
        end
    end

    assign ser_out    = ser_out_reg;
    assign ser_valid  = ser_valid_reg;
    assign busy       = busy_reg;
    assign word_done  = word_done_reg;
    assign load_ready = load_ready_reg;

endmodule : piso_bit_serializer

// File: tb/tb_piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_bit_serializer
// Two serializers (MSB-first and LSB-first) share one stimulus stream. A
// word-queue model predicts every output each cycle; directed scenarios pin
// the model with hand-computed bit streams.
// -----------------------------------------------------------------------------
module tb_piso_bit_serializer;
    import piso_bit_serializer_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         ser_en = 1'b1;

    logic m_load_ready, m_ser_out, m_ser_valid, m_busy, m_word_done;
    logic l_load_ready, l_ser_out, l_ser_valid, l_busy, l_word_done;

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst),
        .load_data(load_data), .load_valid(load_valid), .load_ready(m_load_ready),
        .ser_en(ser_en), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
        .busy(m_busy), .word_done(m_word_done)
    );

    piso_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst),
        .load_data(load_data), .load_valid(load_valid), .load_ready(l_load_ready),
        .ser_en(ser_en), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
        .busy(l_busy), .word_done(l_word_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: a queue of accepted words plus the index of the bit currently
    // on the wire within the head word. Timing is independent of bit order.
    // ------------------------------------------------------------------
    logic [W-1:0] words[$];
    int           pos = 0;
    bit           m_done = 1'b0;

    function automatic logic exp_bit(input bit msb);
        if (words.size() == 0) return 1'b0;
        return msb ? words[0][W-1-pos] : words[0][pos];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            words.delete();
            pos    = 0;
            m_done = 1'b0;
        end else begin
            bit acc;
            cyc++;
            acc    = load_valid && (words.size() < 2);
            m_done = 1'b0;
            if (words.size() > 0 && ser_en) begin
                pos++;
                if (pos == W) begin
                    void'(words.pop_front());
                    pos    = 0;
                    m_done = 1'b1;
                end
            end
            if (acc) words.push_back(load_data);
        end
    end

    // Per-cycle compare against the model, mid-cycle.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("m_valid", m_ser_valid,  words.size() > 0);
            chk("m_out",   m_ser_out,    exp_bit(1'b1));
            chk("m_busy",  m_busy,       words.size() > 0);
            chk("m_ready", m_load_ready, words.size() < 2);
            chk("m_done",  m_word_done,  m_done);
            chk("l_valid", l_ser_valid,  words.size() > 0);
            chk("l_out",   l_ser_out,    exp_bit(1'b0));
            chk("l_busy",  l_busy,       words.size() > 0);
            chk("l_ready", l_load_ready, words.size() < 2);
            chk("l_done",  l_word_done,  m_done);
        end
    end

    // Capture of the serial streams for the directed checks.
    bit cap_m[$];
    bit cap_l[$];
    int done_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (m_ser_valid) cap_m.push_back(m_ser_out);
            if (l_ser_valid) cap_l.push_back(l_ser_out);
            if (m_word_done) done_q.push_back(cyc);
        end
    end

    function automatic logic [31:0] pack(input bit q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    task automatic clear_caps();
        cap_m.delete();
        cap_l.delete();
        done_q.delete();
    endtask

    // Present a word; called at a negedge, returns at the negedge after the
    // accepting edge with load_valid still asserted.
    task automatic send_word(input logic [W-1:0] w);
        bit acc;
        bit ok = 1'b0;
        load_data  = w;
        load_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            acc = (words.size() < 2);
            @(negedge clk);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (words.size() == 0 && !m_ser_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int det_cnt;
        int det_pos;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", m_ser_valid, 1'b0);
        chk("rst_out",   m_ser_out,   1'b0);
        chk("rst_busy",  m_busy,      1'b0);
        chk("rst_done",  m_word_done, 1'b0);
        chk("rst_ready", m_load_ready, 1'b1);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // ---------------- single word ----------------
        clear_caps();
        send_word(8'hA0);
        load_valid = 1'b0;
        wait_idle();
        chk("single_bits", pack(cap_m), 32'h0000_00A0);
        chk("single_len",  cap_m.size(), 8);
        chk("single_done", done_q.size(), 1);
        det_cnt = 0;
        det_pos = -1;
        for (int i = 2; i < cap_m.size(); i++) begin
            if ({cap_m[i-2], cap_m[i-1], cap_m[i]} == DETECT_PATTERN) begin
                det_cnt++;
                if (det_pos < 0) det_pos = i;
            end
        end
        chk("det_count", det_cnt, 1);
        chk("det_pos",   det_pos, 2);

        // ---------------- back-to-back ----------------
        clear_caps();
        send_word(8'hA5);
        send_word(8'h3C);
        chk("b2b_ready_low", m_load_ready, 1'b0);
        load_valid = 1'b0;
        wait_idle();
        chk("b2b_bits",  pack(cap_m), 32'h0000_A53C);
        chk("b2b_len",   cap_m.size(), 16);
        chk("b2b_done",  done_q.size(), 2);
        if (done_q.size() == 2) chk("b2b_spacing", done_q[1] - done_q[0], 8);

        // ---------------- throttle ----------------
        clear_caps();
        send_word(8'hA0);
        load_valid = 1'b0;
        repeat (2) @(negedge clk);
        ser_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("thr_hold_bit", m_ser_out, 1'b1);
        end
        ser_en = 1'b1;
        wait_idle();
        chk("thr_len",  cap_m.size(), 11);
        chk("thr_bits", pack(cap_m), 32'h0000_05E0);

        // ---------------- hold full, third word waits ----------------
        clear_caps();
        send_word(8'hA5);
        send_word(8'h3C);
        load_data = 8'hC3;
        chk("hold_ready_low", m_load_ready, 1'b0);
        send_word(8'hC3);
        load_valid = 1'b0;
        wait_idle();
        chk("hold_bits", pack(cap_m), 32'h00A5_3CC3);
        chk("hold_len",  cap_m.size(), 24);
        chk("hold_done", done_q.size(), 3);

        // ---------------- LSB first ----------------
        clear_caps();
        send_word(8'h05);
        load_valid = 1'b0;
        wait_idle();
        chk("lsb_bits",     pack(cap_l), 32'h0000_00A0);
        chk("lsb_msb_bits", pack(cap_m), 32'h0000_0005);

        // ---------------- reset mid-word ----------------
        send_word(8'hA0);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", m_ser_valid, 1'b0);
        chk("mid_rst_out",   m_ser_out,   1'b0);
        chk("mid_rst_busy",  m_busy,      1'b0);
        chk("mid_rst_ready", m_load_ready, 1'b1);
        chk("mid_rst_done",  m_word_done, 1'b0);
        chk("mid_rst_lbusy", l_busy,      1'b0);
        @(negedge clk);
        rst = 1'b0;
        clear_caps();
        @(negedge clk);
        send_word(8'hA0);
        load_valid = 1'b0;
        wait_idle();
        chk("post_rst_bits", pack(cap_m), 32'h0000_00A0);
        chk("post_rst_len",  cap_m.size(), 8);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            load_valid = ($urandom_range(0, 1) == 1);
            load_data  = W'($urandom);
            ser_en     = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        load_valid = 1'b0;
        ser_en     = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_piso_bit_serializer
